// File: rtl/dfm_pkg.sv
// Shared defaults and types for the measure-result write path.
package dfm_pkg;

    localparam int N_CH   = 5;
    localparam int DATA_W = 64;

    typedef logic [$clog2(N_CH)-1:0] ch_idx_t;
    typedef logic [DATA_W-1:0]       meas_data_t;

    // Index increment that wraps n-1 back to 0 (round-robin pointer advance).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_CH  = dfm_pkg::N_CH,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    // Scan from the farthest candidate back to ptr so the nearest one wins last.
    always_comb begin
        int c;
        c       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            c = int'(ptr) + i;
            if (c >= N_CH) begin
                c = c - N_CH;
            end
            if (req[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/meas_wr_arbiter.sv
// Funnels per-channel measure results into the single regfile write port.
// Each channel owns a one-entry holding buffer; a round-robin arbiter drains
// the buffers one write per cycle, and nothing is granted while the SPI read
// lock (reg_rd_en_i) is high. A strobe that lands on a still-unsent result
// replaces it and raises that channel's sticky overflow flag.
module meas_wr_arbiter #(
    parameter int N_CH   = dfm_pkg::N_CH,
    parameter int DATA_W = dfm_pkg::DATA_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CH-1:0]           raw_wr_en_i,
    input  logic [N_CH*DATA_W-1:0]    raw_wr_data_i,
    input  logic                      reg_rd_en_i,
    input  logic                      ovf_clr_i,
    output logic                      reg_wr_en_o,
    output logic [DATA_W-1:0]         reg_wr_data_o,
    output logic [$clog2(N_CH)-1:0]   reg_wr_ch_o,
    output logic [N_CH-1:0]           ovf_o
);

    import dfm_pkg::*;

    localparam int IDX_W = $clog2(N_CH);

    logic [N_CH-1:0]   pend;
    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   gnt_onehot;
    logic [N_CH-1:0]   ovf_set;
    logic [DATA_W-1:0] hold_data [N_CH];
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;

    assign eligible = pend & {N_CH{~reg_rd_en_i}};

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (eligible),
        .ptr     (ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Decode the grant and flag strobes that would overwrite an unsent result.
    // A strobe on the channel being granted this cycle is not an overflow:
    // the old value leaves on the write port as the new one is captured.
    always_comb begin
        gnt_onehot = '0;
        ovf_set    = '0;
        for (int c = 0; c < N_CH; c++) begin
            gnt_onehot[c] = gnt_vld && (gnt_idx == IDX_W'(c));
            ovf_set[c]    = raw_wr_en_i[c] && pend[c] && !gnt_onehot[c];
        end
    end

    // Pending flags: a new strobe always (re)arms; a grant clears otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (raw_wr_en_i[c]) begin
                    pend[c] <= 1'b1;
                end else if (gnt_onehot[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

    // Holding buffers capture the newest result of each channel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                hold_data[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (raw_wr_en_i[c]) begin
                    hold_data[c] <= raw_wr_data_i[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Registered write port and pointer advance; data/ch hold when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_wr_en_o   <= 1'b0;
            reg_wr_data_o <= '0;
            reg_wr_ch_o   <= '0;
            ptr           <= '0;
        end else if (gnt_vld) begin
            reg_wr_en_o   <= 1'b1;
            reg_wr_data_o <= hold_data[gnt_idx];
            reg_wr_ch_o   <= gnt_idx;
            ptr           <= IDX_W'(wrap_inc(int'(gnt_idx), N_CH));
        end else begin
            reg_wr_en_o   <= 1'b0;
        end
    end

    // Sticky overflow flags; a same-cycle set beats the global clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_o <= '0;
        end else begin
            ovf_o <= (ovf_clr_i ? '0 : ovf_o) | ovf_set;
        end
    end

endmodule

// File: tb/tb_meas_wr_arbiter.sv
// Bench for meas_wr_arbiter: directed scenarios with a write scoreboard.
module tb_meas_wr_arbiter;

    localparam int N  = 5;
    localparam int DW = 64;
    localparam int IW = 3;
    localparam int SW = IW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    raw_wr_en   = '0;
    logic [N*DW-1:0] raw_wr_data = '0;
    logic            reg_rd_en   = 1'b0;
    logic            ovf_clr     = 1'b0;
    logic            reg_wr_en;
    logic [DW-1:0]   reg_wr_data;
    logic [IW-1:0]   reg_wr_ch;
    logic [N-1:0]    ovf;

    meas_wr_arbiter #(.N_CH(N), .DATA_W(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .raw_wr_en_i   (raw_wr_en),
        .raw_wr_data_i (raw_wr_data),
        .reg_rd_en_i   (reg_rd_en),
        .ovf_clr_i     (ovf_clr),
        .reg_wr_en_o   (reg_wr_en),
        .reg_wr_data_o (reg_wr_data),
        .reg_wr_ch_o   (reg_wr_ch),
        .ovf_o         (ovf)
    );

    // ---------------- scoreboard state ----------------
    logic [SW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int n_writes = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_strobe(input int c, input logic [DW-1:0] d);
        raw_wr_en[c] = 1'b1;
        raw_wr_data[c*DW +: DW] = d;
    endtask

    // One-cycle strobe pulse of whatever was set up with set_strobe.
    task automatic pulse();
        tick();
        raw_wr_en = '0;
    endtask

    task automatic expect_wr(input int c, input logic [DW-1:0] d);
        logic [IW-1:0] ch;
        ch = IW'(c);
        exp_q.push_back({ch, d});
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // ---------------- monitor: pop and compare every write ----------------
    always @(negedge clk) begin
        logic [SW-1:0] e;
        if (!rst && reg_wr_en) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", reg_wr_en, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_ch", reg_wr_ch, e[SW-1:DW]);
                chk("wr_data", reg_wr_data, e[DW-1:0]);
            end
        end
    end

    // ---------------- global time limit ----------------
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit reached");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0;

        repeat (3) tick();
        chk("rst_wr_en", reg_wr_en, 1'b0);
        chk("rst_wr_data", reg_wr_data, 0);
        chk("rst_wr_ch", reg_wr_ch, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (2) tick();

        // All five strobes together from ptr=0: back-to-back writes ch0..ch4.
        for (int c = 0; c < N; c++) begin
            set_strobe(c, DW'(64'h10 + c));
            expect_wr(c, DW'(64'h10 + c));
        end
        w0 = n_writes;
        pulse();
        repeat (5) tick();
        chk("t2_burst_count", n_writes - w0, 5);
        wait_drain(20);
        chk("t2_ovf", ovf, 0);

        // Single uncontended strobe on ch2: write appears exactly 2 cycles on.
        repeat (3) tick();
        set_strobe(2, 64'h0000_0000_0001_E240);
        expect_wr(2, 64'h0000_0000_0001_E240);
        pulse();
        chk("t1_en_cycle1", reg_wr_en, 1'b0);
        tick();
        chk("t1_en_cycle2", reg_wr_en, 1'b1);
        tick();
        chk("t1_en_cycle3", reg_wr_en, 1'b0);
        wait_drain(10);

        // ptr=3: ch0 and ch4 together must go ch4 then ch0.
        set_strobe(0, 64'h30);
        set_strobe(4, 64'h34);
        expect_wr(4, 64'h34);
        expect_wr(0, 64'h30);
        pulse();
        wait_drain(10);

        // Read lock: nothing written, second strobe overwrites and flags ovf.
        reg_rd_en = 1'b1;
        tick();
        w0 = n_writes;
        set_strobe(1, 64'hA);
        pulse();
        tick();
        set_strobe(1, 64'hB);
        pulse();
        repeat (16) tick();
        chk("t4_lock_writes", n_writes - w0, 0);
        chk("t4_ovf_set", ovf, 5'b00010);
        expect_wr(1, 64'hB);
        reg_rd_en = 1'b0;
        wait_drain(10);
        chk("t4_ovf_sticky", ovf, 5'b00010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", ovf, 0);

        // Strobe on ch3 coincident with the grant of its pending value.
        set_strobe(3, 64'hD);
        expect_wr(3, 64'hD);
        pulse();
        set_strobe(3, 64'hC);
        expect_wr(3, 64'hC);
        pulse();
        wait_drain(10);
        chk("t5_ovf", ovf, 0);

        // Overflow set on ch0 in the same cycle as ovf_clr: set wins, ch2 clears.
        reg_rd_en = 1'b1;
        tick();
        set_strobe(2, 64'h21);
        pulse();
        set_strobe(2, 64'h22);
        pulse();
        chk("t7_ovf_ch2", ovf, 5'b00100);
        set_strobe(0, 64'h01);
        pulse();
        set_strobe(0, 64'h02);
        ovf_clr = 1'b1;
        pulse();
        ovf_clr = 1'b0;
        chk("t7_ovf_set_wins", ovf, 5'b00001);
        expect_wr(0, 64'h02);
        expect_wr(2, 64'h22);
        reg_rd_en = 1'b0;
        wait_drain(10);

        // Reset with three channels pending: outputs clear at once, pending lost.
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        reg_rd_en = 1'b1;
        set_strobe(1, 64'h61);
        set_strobe(3, 64'h63);
        set_strobe(4, 64'h64);
        pulse();
        set_strobe(1, 64'h71);
        pulse();
        chk("t6_pre_ovf", ovf, 5'b00010);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_wr_en", reg_wr_en, 1'b0);
        chk("t6_rst_wr_data", reg_wr_data, 0);
        chk("t6_rst_wr_ch", reg_wr_ch, 0);
        chk("t6_rst_ovf", ovf, 0);
        tick();
        rst = 1'b0;
        reg_rd_en = 1'b0;
        w0 = n_writes;
        repeat (6) tick();
        chk("t6_no_writes", n_writes - w0, 0);
        set_strobe(3, 64'h83);
        set_strobe(1, 64'h81);
        expect_wr(1, 64'h81);
        expect_wr(3, 64'h83);
        pulse();
        wait_drain(10);

        repeat (3) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
